seq_logic_unit: RTL and testbench

//  Parametrised, slice-serial bitwise logic unit (AND/OR/XOR/NOR) for the ALU datapath.

---
 rtl/alu_pkg.sv | 18 +
 rtl/seq_logic_unit_slice.sv | 26 ++
 rtl/seq_logic_unit.sv | 130 +++++++++++++
 tb/tb_seq_logic_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-op encodings and the sequencer state type
// used by seq_logic_unit.
package alu_pkg;

    typedef enum logic [1:0] {
        LOGIC_AND = 2'b00,
        LOGIC_OR  = 2'b01,
        LOGIC_XOR = 2'b10,
        LOGIC_NOR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_logic_unit_slice.sv
// logic_slice: purely combinational bitwise operation on one SLICE-bit
// operand pair. One instance is shared across all slices of a word.
module logic_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  op_t              op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    // Select the bitwise function for the current slice
    always_comb begin
        y = '0;
        case (op)
            LOGIC_AND: y = a & b;
            LOGIC_OR:  y = a | b;
            LOGIC_XOR: y = a ^ b;
            LOGIC_NOR: y = ~(a | b);
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/seq_logic_unit.sv
// seq_logic_unit: slice-serial AND/OR/XOR/NOR unit. Operands are captured on
// an in_valid/in_ready handshake, SLICE bits are processed per cycle, and the
// result with a zero flag is held until out_valid/out_ready completes.
// Optional parity output/flag enabled by defining SEQ_LOGIC_PARITY_EN.
module seq_logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             zero
`ifdef SEQ_LOGIC_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
        $error("seq_logic_unit: WIDTH must be a non-zero multiple of SLICE");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_t              op_q;
    logic             zero_acc;
    logic [31:0]      base;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] res_sl;
    logic             last_slice;
`ifdef SEQ_LOGIC_PARITY_EN
    logic             parity_acc;
`endif

    assign in_ready   = (state == ST_IDLE);
    assign base       = 32'(cnt) * 32'(SLICE);
    assign a_sl       = a_q[base +: SLICE];
    assign b_sl       = b_q[base +: SLICE];
    assign last_slice = (cnt == CW'(NSLICE - 1));

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op (op_q),
        .a  (a_sl),
        .b  (b_sl),
        .y  (res_sl)
    );

    // Sequencer: capture operands, walk the slices, hold result until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= LOGIC_AND;
            Y         <= '0;
            zero      <= 1'b0;
            zero_acc  <= 1'b0;
            out_valid <= 1'b0;
`ifdef SEQ_LOGIC_PARITY_EN
            parity     <= 1'b0;
            parity_acc <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        op_q     <= op_t'(op);
                        Y        <= '0;
                        cnt      <= '0;
                        zero     <= 1'b0;
                        zero_acc <= 1'b0;
`ifdef SEQ_LOGIC_PARITY_EN
                        parity     <= 1'b0;
                        parity_acc <= 1'b0;
`endif
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    Y[base +: SLICE] <= res_sl;
                    zero_acc         <= zero_acc | (|res_sl);
`ifdef SEQ_LOGIC_PARITY_EN
                    parity_acc       <= parity_acc ^ (^res_sl);
`endif
                    if (last_slice) begin
                        // Flags fold in the final slice directly since the
                        // accumulators only update at this same edge.
                        zero      <= ~(zero_acc | (|res_sl));
`ifdef SEQ_LOGIC_PARITY_EN
                        parity    <= parity_acc ^ (^res_sl);
`endif
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_logic_unit.sv
// Self-checking bench for seq_logic_unit: a WIDTH=32/SLICE=8 instance for the
// slice-serial path and a SLICE=32 instance for the single-slice case.
module tb_seq_logic_unit;

    localparam int W  = 32;
    localparam int S  = 8;
    localparam int NS = W / S;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Multi-slice instance
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Y;
    logic          zero;
`ifdef SEQ_LOGIC_PARITY_EN
    logic          parity;
`endif

    // Single-slice instance
    logic          f_in_valid;
    logic          f_in_ready;
    logic [1:0]    f_op;
    logic [W-1:0]  f_A;
    logic [W-1:0]  f_B;
    logic          f_out_valid;
    logic          f_out_ready;
    logic [W-1:0]  f_Y;
    logic          f_zero;
`ifdef SEQ_LOGIC_PARITY_EN
    logic          f_parity;
`endif

    int checks = 0;
    int errors = 0;

    seq_logic_unit #(.WIDTH(W), .SLICE(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .zero      (zero)
`ifdef SEQ_LOGIC_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    seq_logic_unit #(.WIDTH(W), .SLICE(W)) dut_full (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (f_in_valid),
        .in_ready  (f_in_ready),
        .op        (f_op),
        .A         (f_A),
        .B         (f_B),
        .out_valid (f_out_valid),
        .out_ready (f_out_ready),
        .Y         (f_Y),
        .zero      (f_zero)
`ifdef SEQ_LOGIC_PARITY_EN
        ,
        .parity    (f_parity)
`endif
    );

    // Reference: the bitwise function named by the op code on whole words
    function automatic logic [W-1:0] ref_logic(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // One full transaction on the multi-slice instance with `hold` cycles of backpressure
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int cyc;
        logic [W-1:0] ey;
        ey = ref_logic(o, a, b);
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait in_ready=%b required 1", in_ready);
        end
        op = o; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; op = 2'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready in_ready=%b required 0", in_ready);
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc != NS) begin
            errors++;
            $display("FAIL latency cycles=%0d required %0d", cyc, NS);
        end
        checks++;
        if (Y !== ey) begin
            errors++;
            $display("FAIL result op=%0d A=%h B=%h Y=%h required %h", o, a, b, Y, ey);
        end
        checks++;
        if (zero !== (ey == '0)) begin
            errors++;
            $display("FAIL zero_flag zero=%b required %b", zero, (ey == '0));
        end
`ifdef SEQ_LOGIC_PARITY_EN
        checks++;
        if (parity !== (^ey)) begin
            errors++;
            $display("FAIL parity parity=%b required %b", parity, ^ey);
        end
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'(($urandom));
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || Y !== ey || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold out_valid=%b Y=%h in_ready=%b required 1 %h 0", out_valid, Y, in_ready, ey);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; A = '0; B = '0;
        f_in_valid = 1'b0; f_out_ready = 1'b0; f_op = 2'b00; f_A = '0; f_B = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || Y !== '0 || zero !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state out_valid=%b Y=%h zero=%b in_ready=%b required 0 0 0 1", out_valid, Y, zero, in_ready);
        end
        checks++;
        if (f_out_valid !== 1'b0 || f_Y !== '0 || f_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state_full out_valid=%b Y=%h in_ready=%b required 0 0 1", f_out_valid, f_Y, f_in_ready);
        end
`ifdef SEQ_LOGIC_PARITY_EN
        checks++;
        if (parity !== 1'b0) begin
            errors++;
            $display("FAIL reset_parity parity=%b required 0", parity);
        end
`endif
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 0);
        run_op(2'b00, 32'hAAAAAAAA, 32'h55555555, 0);
        run_op(2'b11, 32'h00000000, 32'h00000000, 0);
    endtask

    task automatic test_backpressure();
        run_op(2'b01, 32'h0000FF00, 32'h00F00000, 5);
    endtask

    task automatic test_reset_abort();
        op = 2'b01; A = 32'hFFFFFFFF; B = 32'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || Y !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort out_valid=%b Y=%h in_ready=%b required 0 0 1", out_valid, Y, in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(2'b10, 32'h12345678, 32'h0F0F0F0F, 1);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   o;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            o = 2'($urandom_range(0, 3));
            if (i % 5 == 0) begin
                o = 2'b00;
                b = ~a;
            end
            run_op(o, a, b, $urandom_range(0, 3));
        end
    endtask

    task automatic test_single_slice();
        logic [W-1:0] ey;
        f_op = 2'b01; f_A = 32'h12340000; f_B = 32'h00005678; f_in_valid = 1'b1;
        @(posedge clk); #1;
        f_in_valid = 1'b0;
        f_A = 32'hDEADBEEF;
        checks++;
        if (f_out_valid !== 1'b0 || f_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_run out_valid=%b in_ready=%b required 0 0", f_out_valid, f_in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (f_out_valid !== 1'b1 || f_Y !== 32'h12345678 || f_zero !== 1'b0) begin
            errors++;
            $display("FAIL full_result out_valid=%b Y=%h zero=%b required 1 12345678 0", f_out_valid, f_Y, f_zero);
        end
        f_out_ready = 1'b1;
        @(posedge clk); #1;
        f_out_ready = 1'b0;
        checks++;
        if (f_in_ready !== 1'b1 || f_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_release in_ready=%b out_valid=%b required 1 0", f_in_ready, f_out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            f_op = 2'($urandom_range(0, 3)); f_A = $urandom; f_B = $urandom;
            ey = ref_logic(f_op, f_A, f_B);
            f_in_valid = 1'b1;
            @(posedge clk); #1;
            f_in_valid = 1'b0;
            f_B = $urandom;
            @(posedge clk); #1;
            checks++;
            if (f_out_valid !== 1'b1 || f_Y !== ey || f_zero !== (ey == '0)) begin
                errors++;
                $display("FAIL full_random out_valid=%b Y=%h zero=%b required 1 %h %b", f_out_valid, f_Y, f_zero, ey, (ey == '0));
            end
`ifdef SEQ_LOGIC_PARITY_EN
            checks++;
            if (f_parity !== (^ey)) begin
                errors++;
                $display("FAIL full_parity parity=%b required %b", f_parity, ^ey);
            end
`endif
            f_out_ready = 1'b1;
            @(posedge clk); #1;
            f_out_ready = 1'b0;
        end
    endtask

    task automatic test_parity();
        run_op(2'b10, 32'h00000007, 32'h00000000, 0);
        run_op(2'b10, 32'h00000003, 32'h00000000, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_single_slice();
        test_parity();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
